// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller
//
// Time-multiplexes the Nexys4 8-digit seven-segment display. Game logic writes a
// packed hex value with a one-cycle load strobe; the value is double-buffered
// (pending -> active at the frame boundary) so a frame never tears. Each digit
// slot has a fixed length and starts with a blank gap (all anodes off) to stop
// ghosting between neighbouring digits.
//
// Parameters:
//   NUM_DIGITS    digits scanned (1..8); An[7:NUM_DIGITS] stay high
//   SLOT_CYCLES   clock cycles per digit slot
//   BLANK_CYCLES  blank cycles at the start of each slot (1 <= BLANK < SLOT)
//
// Ports:
//   ClkPort     in   1   system clock
//   Reset_n     in   1   synchronous reset, active-low
//   load        in   1   strobe: capture value/digit_en/dp_en into pending buffer
//   value       in   32  nibble i = hex digit i (digit 0 rightmost)
//   digit_en    in   8   1 = digit i shown
//   dp_en       in   8   1 = decimal point i lit
//   An          out  8   anodes, active-low, registered
//   Cathodes    out  8   {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, registered
//   frame_done  out  1   high for the last cycle of the last digit slot
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (above digit 0) are
//                          forced dark when the pending buffer is made active.

module ssd_scan_controller #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SLOT_CYCLES  = 262144,
    parameter int unsigned BLANK_CYCLES = 1024
) (
    input  logic        ClkPort,
    input  logic        Reset_n,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_en,
    output logic [7:0]  An,
    output logic [7:0]  Cathodes,
    output logic        frame_done
);

    localparam int unsigned CntW = $clog2(SLOT_CYCLES);
    localparam logic [CntW-1:0] CntLast  = CntW'(SLOT_CYCLES - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);
    localparam logic [2:0]      IdxLast  = 3'(NUM_DIGITS - 1);

    // Scan position
    logic [CntW-1:0] cnt;
    logic [2:0]      idx;

    // Pending and active display buffers
    logic [31:0] pend_value;
    logic [7:0]  pend_en;
    logic [7:0]  pend_dp;
    logic [31:0] act_value;
    logic [7:0]  act_en;
    logic [7:0]  act_dp;

    // Next-state signals
    logic            slot_end;
    logic            frame_end;
    logic [CntW-1:0] cnt_next;
    logic [2:0]      idx_next;
    logic [31:0]     src_value;
    logic [7:0]      src_en;
    logic [7:0]      src_dp;
    logic [7:0]      act_en_next;
    logic [3:0]      nibble;
    logic [7:0]      an_next;
    logic [7:0]      cath_next;

    // Hex to abcdefg, active-low
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Counter next state
    always_comb begin
        slot_end  = (cnt == CntLast);
        frame_end = slot_end && (idx == IdxLast);
        cnt_next  = cnt + CntW'(1);
        idx_next  = idx;
        if (slot_end) begin
            cnt_next = '0;
            idx_next = (idx == IdxLast) ? 3'd0 : idx + 3'd1;
        end
    end

    // Source for the active buffer: a load landing on the boundary cycle bypasses pending
    always_comb begin
        if (load) begin
            src_value = value;
            src_en    = digit_en;
            src_dp    = dp_en;
        end else begin
            src_value = pend_value;
            src_en    = pend_en;
            src_dp    = pend_dp;
        end
    end

    // Digit enables as they will be made active
`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;
    always_comb begin
        act_en_next = src_en;
        zero_above  = 1'b1;
        // Walk down from the top scanned digit; stop suppressing at the first non-zero nibble
        for (int i = 7; i >= 1; i--) begin
            if (i < int'(NUM_DIGITS)) begin
                zero_above = zero_above & (src_value[4*i +: 4] == 4'h0);
                if (zero_above) begin
                    act_en_next[i] = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        act_en_next = src_en;
    end
`endif

    // Output decode from the current scan position and active buffer
    always_comb begin
        nibble    = act_value[{idx, 2'b00} +: 4];
        an_next   = 8'hFF;
        cath_next = 8'hFF;
        if ((cnt >= CntBlank) && act_en[idx]) begin
            an_next[idx] = 1'b0;
            cath_next    = {seg7(nibble), ~act_dp[idx]};
        end
    end

    always_ff @(posedge ClkPort) begin
        if (!Reset_n) begin
            cnt        <= '0;
            idx        <= 3'd0;
            pend_value <= 32'h0;
            pend_en    <= 8'h00;
            pend_dp    <= 8'h00;
            act_value  <= 32'h0;
            act_en     <= 8'h00;
            act_dp     <= 8'h00;
            An         <= 8'hFF;
            Cathodes   <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            idx        <= idx_next;
            An         <= an_next;
            Cathodes   <= cath_next;
            // Registered so it is high exactly while the scan sits on the boundary cycle
            frame_done <= (cnt_next == CntLast) && (idx_next == IdxLast);
            if (load) begin
                pend_value <= value;
                pend_en    <= digit_en;
                pend_dp    <= dp_en;
            end
            if (frame_end) begin
                act_value <= src_value;
                act_en    <= act_en_next;
                act_dp    <= src_dp;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
module tb_ssd_scan_controller;

    localparam int N = 4;
    localparam int S = 16;
    localparam int B = 4;
    localparam int F = N * S;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit Lzb = 1'b1;
`else
    localparam bit Lzb = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [7:0]  dp_en;
    logic [7:0]  an;
    logic [7:0]  cath;
    logic        fd;

    always #5 clk = ~clk;

    ssd_scan_controller #(
        .NUM_DIGITS  (N),
        .SLOT_CYCLES (S),
        .BLANK_CYCLES(B)
    ) dut (
        .ClkPort   (clk),
        .Reset_n   (rst_n),
        .load      (load),
        .value     (value),
        .digit_en  (digit_en),
        .dp_en     (dp_en),
        .An        (an),
        .Cathodes  (cath),
        .frame_done(fd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position in the scan stream since reset, plus the two buffers
    int          pos;
    logic [31:0] p_val, a_val;
    logic [7:0]  p_en, a_en, p_dp, a_dp;
    logic [6:0]  seg_tab [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t pos=%0d got=%h exp=%h", tag, $time, pos, got, exp);
        end
    endtask

    // Leading-zero suppression: digits above the highest non-zero nibble go dark
    function automatic logic [7:0] shown_en(input logic [31:0] v, input logic [7:0] e);
        int top = 0;
        logic [7:0] r = e;
        for (int i = 0; i < N; i++) begin
            if (v[4*i +: 4] != 4'h0) top = i;
        end
        if (Lzb) begin
            for (int i = top + 1; i < N; i++) r[i] = 1'b0;
        end
        return r;
    endfunction

    // One clock: predict outputs, clock the DUT, compare, release the load strobe
    task automatic tick();
        logic [7:0] e_an, e_cath;
        logic       e_fd;
        int         slot, off;
        e_an   = 8'hFF;
        e_cath = 8'hFF;
        e_fd   = 1'b0;
        if (!rst_n) begin
            pos   = 0;
            p_val = '0; p_en = '0; p_dp = '0;
            a_val = '0; a_en = '0; a_dp = '0;
        end else begin
            slot = (pos / S) % N;
            off  = pos % S;
            if (off >= B && a_en[slot]) begin
                e_an[slot] = 1'b0;
                e_cath     = {seg_tab[a_val[4*slot +: 4]], ~a_dp[slot]};
            end
            if (load) begin
                p_val = value; p_en = digit_en; p_dp = dp_en;
            end
            if (pos % F == F - 1) begin
                a_val = p_val;
                a_en  = shown_en(p_val, p_en);
                a_dp  = p_dp;
            end
            pos++;
            e_fd = (pos % F == F - 1);
        end
        @(posedge clk);
        #1;
        check_eq("an", {24'h0, an}, {24'h0, e_an});
        check_eq("cath", {24'h0, cath}, {24'h0, e_cath});
        check_eq("frame_done", {31'h0, fd}, {31'h0, e_fd});
        load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] e, input logic [7:0] d);
        load     = 1'b1;
        value    = v;
        digit_en = e;
        dp_en    = d;
        tick();
    endtask

    // Advance until the next tick would land on the given frame offset (reset must be high)
    task automatic run_to(input int frame_off);
        while (pos % F != frame_off) tick();
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        pos      = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        digit_en = '0;
        dp_en    = '0;
        @(negedge clk);

        // Reset, then an empty display with the frame pulse running
        run(3);
        rst_n = 1'b1;
        run(2 * F);

        // 1234 with the decimal point on digit 1
        do_load(32'h0000_1234, 8'h0F, 8'h02);
        run(2 * F);

        // Two loads in one frame: the later wins, the current frame is untouched
        run(20);
        do_load(32'h5, 8'h0F, 8'h00);
        run(1);
        do_load(32'h6, 8'h0F, 8'h00);
        run(F + 10);

        // Load on the boundary cycle goes straight to the next slot 0
        run_to(F - 1);
        do_load(32'h9, 8'h0F, 8'h01);
        run(F);

        // Sparse enables keep slot timing
        do_load(32'h0000_ABCD, 8'h05, 8'hFF);
        run(2 * F);

        // Reset while digit 2 is being driven
        run_to(2 * S + 8);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(2 * F);

        // Leading zeros, and an all-zero value
        do_load(32'h0000_0070, 8'h0F, 8'h00);
        run(2 * F);
        do_load(32'h0, 8'h0F, 8'h00);
        run(2 * F);

        // Randomized loads and occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 30) == 0 || (rst_n && pos % F == F - 1 && $urandom_range(0, 1) == 1)) begin
                load     = 1'b1;
                value    = $urandom;
                digit_en = 8'($urandom);
                dp_en    = 8'($urandom);
                if ($urandom_range(0, 3) == 0) value = value & 32'h0000_00FF;
            end
            rst_n = ($urandom_range(0, 400) != 0);
            tick();
        end
        rst_n = 1'b1;
        run(F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
